mem_write_checker: RTL

- Synthesizable self-check stage directly downstream of the processor top: consumes its data-memory write port (MemWrite, DataAdr, WriteData) every clock.
- Decides pass / fail / timeout for the standard program-completion protocol: repeated scratch stores to address 96, then terminal store of 7 to address 100.
- Optionally keeps a trace FIFO of observed writes for readout by the bench or a debug port.
- Replaces the behavioural negedge checker so the same check runs in simulation and on FPGA.

---
 rtl/mem_write_checker.sv | 103 ++++++++++
 1 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker: decides pass/fail/timeout from the processor's data-memory write port.
//   Optional trace FIFO built when TRACE_FIFO_EN is defined.
//   Ports: clk, reset (sync, active-high); MemWrite/DataAdr/WriteData observed store port;
//   done/pass/fail/timeout registered verdict; write_count saturating scratch-store count;
//   fail_adr/fail_data offending store; trace_rd/trace_data/trace_empty/trace_full/trace_ovf
//   show-ahead trace FIFO of observed stores.
module mem_write_checker #(
  parameter logic [31:0] PASS_ADR = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter logic [31:0] SCRATCH_ADR = 32'd96,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] write_count,
  output logic [31:0]      fail_adr,
  output logic [31:0]      fail_data,
  input  logic             trace_rd,
  output logic [63:0]      trace_data,
  output logic             trace_empty,
  output logic             trace_full,
  output logic             trace_ovf
);
  typedef enum logic [1:0] {RUN, PASSED, FAILED, TIMEDOUT} state_t;
  state_t state, nextState;
  logic [CNT_W-1:0] cycleCnt;
  logic inRun, isPassWr, isBadWr, isScratchWr, lastCycle;
  assign inRun = state == RUN;
  assign isPassWr = MemWrite && DataAdr == PASS_ADR && WriteData == PASS_DATA;
  assign isBadWr = MemWrite && !isPassWr && DataAdr != SCRATCH_ADR;
  assign isScratchWr = MemWrite && !isPassWr && DataAdr == SCRATCH_ADR;
  assign lastCycle = cycleCnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // Terminal writes take precedence over the timeout in the same cycle.
  always_comb begin
    nextState = state;
    if (inRun) nextState = isPassWr ? PASSED : isBadWr ? FAILED : lastCycle ? TIMEDOUT : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cycleCnt <= '0;
      write_count <= '0;
      fail_adr <= '0;
      fail_data <= '0;
    end else begin
      state <= nextState;
      if (inRun) begin
        cycleCnt <= cycleCnt + CNT_W'(1);
        if (isScratchWr && write_count != '1) write_count <= write_count + CNT_W'(1);
        if (isBadWr) begin
          fail_adr <= DataAdr;
          fail_data <= WriteData;
        end
      end
    end
  end
  assign pass = state == PASSED;
  assign fail = state == FAILED;
  assign timeout = state == TIMEDOUT;
  assign done = !inRun;
`ifdef TRACE_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic wrReq, push, pop, ovf;
  assign wrReq = MemWrite && inRun;
  assign pop = trace_rd && !trace_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push = wrReq && (!trace_full || pop);
  assign trace_empty = wrPtr == rdPtr;
  assign trace_full = (wrPtr ^ rdPtr) == {1'b1, {AW{1'b0}}};
  assign trace_data = trace_empty ? '0 : mem[rdPtr[AW-1:0]];
  assign trace_ovf = ovf;
  always_ff @(posedge clk) if (push) mem[wrPtr[AW-1:0]] <= {DataAdr, WriteData};
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (wrReq && !push) ovf <= 1'b1;
    end
  end
`else
  logic unusedTraceRd;
  assign unusedTraceRd = trace_rd;
  assign trace_empty = 1'b1;
  assign trace_full = 1'b0;
  assign trace_ovf = 1'b0;
  assign trace_data = '0;
`endif
endmodule
